instruction_fetch: RTL



---
 rtl/mips_pkg.sv | 21 ++
 rtl/instruction_fetch_if.sv | 44 ++++
 rtl/instruction_memory.sv | 33 +++
 rtl/instruction_fetch.sv | 113 +++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared constants and types for the MIPS pipeline front end.
//   HALT_INSTR   : all-ones word that stops instruction fetch
//   NOP_INSTR    : word fed downstream while the fetch stage is not running
//   PC_INCREMENT : byte distance between sequential instructions
//   if_state_e   : instruction-fetch FSM states (IDLE / RUN / HALTED)
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam logic [31:0] HALT_INSTR   = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam int          PC_INCREMENT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } if_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_if
// Bundle of control, loader and output signals of the IF stage.
//   master : pipeline control / loader side (drives i_*, observes o_*)
//   slave  : the instruction_fetch stage (observes i_*, drives o_*)
// Signals:
//   i_enable, i_start, i_pc_src, i_branch_target : pipeline control
//   i_load_en, i_load_addr, i_load_data          : program loader port
//   o_pc, o_next_seq_pc, o_instruction, o_halt   : fetch results for IF/ID
//   o_fetch_count                                : fetch counter (0 if disabled)
// ---------------------------------------------------------------------------
interface instruction_fetch_if #(
  parameter int PC_SIZE          = 32,
  parameter int INSTRUCTION_SIZE = 32,
  parameter int MEM_DEPTH        = 256,
  parameter int ADDR_W           = $clog2(MEM_DEPTH)
);

  logic                        i_enable;
  logic                        i_start;
  logic                        i_pc_src;
  logic [PC_SIZE-1:0]          i_branch_target;
  logic                        i_load_en;
  logic [ADDR_W-1:0]           i_load_addr;
  logic [INSTRUCTION_SIZE-1:0] i_load_data;
  logic [PC_SIZE-1:0]          o_pc;
  logic [PC_SIZE-1:0]          o_next_seq_pc;
  logic [INSTRUCTION_SIZE-1:0] o_instruction;
  logic                        o_halt;
  logic [31:0]                 o_fetch_count;

  modport master (
    output i_enable, i_start, i_pc_src, i_branch_target,
           i_load_en, i_load_addr, i_load_data,
    input  o_pc, o_next_seq_pc, o_instruction, o_halt, o_fetch_count
  );

  modport slave (
    input  i_enable, i_start, i_pc_src, i_branch_target,
           i_load_en, i_load_addr, i_load_data,
    output o_pc, o_next_seq_pc, o_instruction, o_halt, o_fetch_count
  );

endinterface

// File: rtl/instruction_memory.sv
// ---------------------------------------------------------------------------
// instruction_memory
// MEM_DEPTH x INSTRUCTION_SIZE program store.
//   i_clk                          : clock
//   i_wr_en, i_wr_addr, i_wr_data  : synchronous write port (loader)
//   i_rd_addr, o_rd_data           : asynchronous read port (fetch)
// Contents are not affected by reset so a loaded program survives it.
// ---------------------------------------------------------------------------
module instruction_memory #(
  parameter int INSTRUCTION_SIZE = 32,
  parameter int MEM_DEPTH        = 256,
  parameter int ADDR_W           = $clog2(MEM_DEPTH)
) (
  input  logic                        i_clk,
  input  logic                        i_wr_en,
  input  logic [ADDR_W-1:0]           i_wr_addr,
  input  logic [INSTRUCTION_SIZE-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]           i_rd_addr,
  output logic [INSTRUCTION_SIZE-1:0] o_rd_data
);

  logic [INSTRUCTION_SIZE-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Combinational read: the instruction is valid in the same cycle as the PC.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// IF stage of the 5-stage MIPS pipeline. Holds the PC, the instruction
// memory (filled by the loader while IDLE), selects the next PC and detects
// HALT. Presents {next sequential PC, instruction, halt} to IF/ID.
// Ports:
//   i_clk   : clock
//   i_reset : synchronous active-high reset (state IDLE, PC 0, counter 0)
//   bus     : instruction_fetch_if.slave (control, loader and outputs)
// Optional feature macro IFETCH_PERF_CNT_EN: when defined, o_fetch_count
// counts enabled RUN edges; otherwise o_fetch_count is tied to 0.
// ---------------------------------------------------------------------------
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int PC_SIZE          = 32,
  parameter int INSTRUCTION_SIZE = 32,
  parameter int MEM_DEPTH        = 256,
  parameter int ADDR_W           = $clog2(MEM_DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  instruction_fetch_if.slave  bus
);

  if_state_e                   r_state;
  logic [PC_SIZE-1:0]          r_pc;
  logic [INSTRUCTION_SIZE-1:0] w_mem_data;
  logic                        w_running;
  logic                        w_halt;
  logic                        w_load_en;
  logic [PC_SIZE-1:0]          w_seq_pc;
  logic [PC_SIZE-1:0]          w_target;

  assign w_running = (r_state == RUN);
  // Loader writes are only accepted while IDLE.
  assign w_load_en = (r_state == IDLE) && bus.i_load_en;
  assign w_seq_pc  = r_pc + PC_SIZE'(PC_INCREMENT);
  // Redirect targets are forced word aligned.
  assign w_target  = bus.i_branch_target & ~PC_SIZE'(3);
  // A branch resolved in the same cycle squashes a fetched HALT.
  assign w_halt    = w_running && (w_mem_data == INSTRUCTION_SIZE'(HALT_INSTR))
                     && !bus.i_pc_src;

  instruction_memory #(
    .INSTRUCTION_SIZE (INSTRUCTION_SIZE),
    .MEM_DEPTH        (MEM_DEPTH),
    .ADDR_W           (ADDR_W)
  ) u_imem (
    .i_clk     (i_clk),
    .i_wr_en   (w_load_en),
    .i_wr_addr (bus.i_load_addr),
    .i_wr_data (bus.i_load_data),
    .i_rd_addr (r_pc[ADDR_W+1:2]),
    .o_rd_data (w_mem_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pc <= '0;
          if (bus.i_start) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (bus.i_enable) begin
            if (bus.i_pc_src) begin
              r_pc <= w_target;
            end else if (w_halt) begin
              // PC stays on the HALT word.
              r_state <= HALTED;
            end else begin
              r_pc <= w_seq_pc;
            end
          end
        end
        HALTED: begin
          r_state <= HALTED;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetch_count <= '0;
    end else if (w_running && bus.i_enable) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign bus.o_fetch_count = r_fetch_count;
`else
  assign bus.o_fetch_count = '0;
`endif

  assign bus.o_pc          = r_pc;
  assign bus.o_next_seq_pc = w_seq_pc;
  assign bus.o_instruction = w_running ? w_mem_data : INSTRUCTION_SIZE'(NOP_INSTR);
  assign bus.o_halt        = w_halt;

endmodule
